// File: rtl/dmi_arbiter_if.sv
// rtl/dmi_arbiter_if.sv - DMI request/response channel bundle
// master drives requests and accepts responses; slave is the opposite end.
interface dmi_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_bits_addr;
  logic [1:0]  req_bits_op;
  logic [31:0] req_bits_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_bits_resp;
  logic [31:0] resp_bits_data;

  modport master (
    output req_valid, req_bits_addr, req_bits_op, req_bits_data, resp_ready,
    input  req_ready, resp_valid, resp_bits_resp, resp_bits_data
  );

  modport slave (
    input  req_valid, req_bits_addr, req_bits_op, req_bits_data, resp_ready,
    output req_ready, resp_valid, resp_bits_resp, resp_bits_data
  );
endinterface

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - two-requester DMI arbiter with response timeout
// One transaction in flight; responses return to the issuing requester.
module dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  dmi_arbiter_if.slave        m0,
  dmi_arbiter_if.slave        m1,
  dmi_arbiter_if.master       debug,
  output logic                busy,
  output logic [7:0]          timeouts
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [6:0]  r_addr;
  logic [1:0]  r_op;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [31:0] r_rdata;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_timeouts;
  logic        r_busy;

  logic        w_idle;
  logic        w_issue;
  logic        w_wait;
  logic        w_deliver;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_take;
  logic        w_owner_ready;

  // Readies are held low while reset is asserted, even though the state is already IDLE.
  assign w_idle    = (r_state == IDLE) && reset_n;
  assign w_issue   = (r_state == ISSUE);
  assign w_wait    = (r_state == WAIT);
  assign w_deliver = (r_state == DELIVER);

  assign w_gnt1 = m1.req_valid && (!m0.req_valid || !r_last);
  assign w_gnt0 = m0.req_valid && !w_gnt1;
  assign w_take = w_idle && (w_gnt0 || w_gnt1);
  assign w_owner_ready = r_owner ? m1.resp_ready : m0.resp_ready;

  assign m0.req_ready = w_idle && w_gnt0;
  assign m1.req_ready = w_idle && w_gnt1;

  assign debug.req_valid     = w_issue;
  assign debug.req_bits_addr = w_issue ? r_addr : '0;
  assign debug.req_bits_op   = w_issue ? r_op   : '0;
  assign debug.req_bits_data = w_issue ? r_data : '0;
  assign debug.resp_ready    = w_idle || w_wait;

  assign m0.resp_valid     = w_deliver && !r_owner;
  assign m0.resp_bits_resp = (w_deliver && !r_owner) ? r_resp  : '0;
  assign m0.resp_bits_data = (w_deliver && !r_owner) ? r_rdata : '0;
  assign m1.resp_valid     = w_deliver && r_owner;
  assign m1.resp_bits_resp = (w_deliver && r_owner) ? r_resp  : '0;
  assign m1.resp_bits_data = (w_deliver && r_owner) ? r_rdata : '0;

  assign busy     = r_busy;
  assign timeouts = r_timeouts;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_addr     <= '0;
      r_op       <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_timeouts <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
            r_addr  <= w_gnt1 ? m1.req_bits_addr : m0.req_bits_addr;
            r_op    <= w_gnt1 ? m1.req_bits_op   : m0.req_bits_op;
            r_data  <= w_gnt1 ? m1.req_bits_data : m0.req_bits_data;
            r_state <= ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (debug.req_ready) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the last wait cycle takes priority over the timeout.
          if (debug.resp_valid) begin
            r_resp  <= debug.resp_bits_resp;
            r_rdata <= debug.resp_bits_data;
            r_state <= DELIVER;
          end else if (r_cnt == CNT_LAST) begin
            r_resp  <= 2'b10;
            r_rdata <= '0;
            if (r_timeouts != 8'hFF) begin
              r_timeouts <= r_timeouts + 8'd1;
            end
            r_state <= DELIVER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DELIVER: begin
          if (w_owner_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
